// File: rtl/data_memory_controller.sv
// Byte-addressed data memory controller with a valid/ready request/response handshake.
// It supports sub-doubleword loads and stores and reports misaligned accesses.
module data_memory_controller #(
    parameter int ADDR_WIDTH      = 11,
    parameter int FAULT_CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       reqValid,
    output logic                       reqReady,
    input  logic                       reqWrite,
    input  logic [ADDR_WIDTH-1:0]      reqAddr,
    input  logic [1:0]                 reqSize,
    input  logic                       reqSigned,
    input  logic [63:0]                reqWData,
    output logic                       respValid,
    input  logic                       respReady,
    output logic [63:0]                respRData,
    output logic                       respFault,
    output logic [FAULT_CNT_WIDTH-1:0] faultCount
);

    localparam int DEPTH = 2**(ADDR_WIDTH-3);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                       r_write;
    logic                       r_signed;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic [1:0]                 r_size;
    logic [63:0]                r_wdata;
    logic [63:0]                r_rdata;
    logic                       r_fault;
    logic [FAULT_CNT_WIDTH-1:0] r_fcnt;
    logic [63:0]                r_mem [0:DEPTH-1];

    logic                  w_accept;
    logic [2:0]            w_off;
    logic [ADDR_WIDTH-4:0] w_idx;
    logic                  w_misalign;
    logic [7:0]            w_size_mask;
    logic [7:0]            w_lane_en;
    logic [63:0]           w_wshift;
    logic [63:0]           w_rword;
    logic [63:0]           w_field;
    logic [63:0]           w_load;
    logic                  w_commit;

    assign reqReady   = (r_state == IDLE);
    assign respValid  = (r_state == RESP);
    assign respRData  = r_rdata;
    assign respFault  = r_fault;
    assign faultCount = r_fcnt;

    assign w_accept = reqValid & reqReady;
    assign w_off    = r_addr[2:0];
    assign w_idx    = r_addr[ADDR_WIDTH-1:3];
    assign w_rword  = r_mem[w_idx];
    assign w_field  = w_rword >> {w_off, 3'b000};
    assign w_wshift = r_wdata << {w_off, 3'b000};
    assign w_lane_en = w_size_mask << w_off;
    // Gating on resetN drops a store caught by reset in ACCESS.
    assign w_commit = resetN & (r_state == ACCESS) & r_write & ~w_misalign;

    always_comb begin
        w_misalign  = 1'b0;
        w_size_mask = 8'h01;
        w_load      = '0;
        unique case (r_size)
            2'd0: begin
                w_misalign  = 1'b0;
                w_size_mask = 8'h01;
                w_load      = {{56{w_field[7] & r_signed}}, w_field[7:0]};
            end
            2'd1: begin
                w_misalign  = r_addr[0];
                w_size_mask = 8'h03;
                w_load      = {{48{w_field[15] & r_signed}}, w_field[15:0]};
            end
            2'd2: begin
                w_misalign  = |r_addr[1:0];
                w_size_mask = 8'h0F;
                w_load      = {{32{w_field[31] & r_signed}}, w_field[31:0]};
            end
            default: begin
                w_misalign  = |r_addr[2:0];
                w_size_mask = 8'hFF;
                w_load      = w_field;
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    if (respReady) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state  <= IDLE;
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_size   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_fault  <= 1'b0;
            r_fcnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write  <= reqWrite;
                r_signed <= reqSigned;
                r_addr   <= reqAddr;
                r_size   <= reqSize;
                r_wdata  <= reqWData;
            end
            if (r_state == ACCESS) begin
                r_fault <= w_misalign;
                r_rdata <= (w_misalign | r_write) ? 64'd0 : w_load;
                if (w_misalign && (r_fcnt != '1)) begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int k = 0; k < 8; k++) begin
                if (w_lane_en[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wshift[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_controller.sv
// Testbench for data_memory_controller: directed scenarios followed by random traffic,
// all checked against a byte-array reference model.
module tb_data_memory_controller;

    logic        clk;
    logic        resetN;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [10:0] reqAddr;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [63:0] reqWData;
    logic        respValid;
    logic        respReady;
    logic [63:0] respRData;
    logic        respFault;
    logic [7:0]  faultCount;

    int checks;
    int failures;

    logic [7:0] mm [0:2047];
    int         mcnt;

    data_memory_controller #(
        .ADDR_WIDTH(11),
        .FAULT_CNT_WIDTH(8)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .reqValid(reqValid),
        .reqReady(reqReady),
        .reqWrite(reqWrite),
        .reqAddr(reqAddr),
        .reqSize(reqSize),
        .reqSigned(reqSigned),
        .reqWData(reqWData),
        .respValid(respValid),
        .respReady(respReady),
        .respRData(respRData),
        .respFault(respFault),
        .faultCount(faultCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_load(input int addr, input int size,
                                               input bit sgn);
        int n;
        logic [63:0] v;
        n = 1 << size;
        v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(mm[addr+i]) << (8*i));
        if (sgn && n < 8 && v[8*n-1]) v = v | ({64{1'b1}} << (8*n));
        return v;
    endfunction

    task automatic xact(input bit w, input int addr, input int size,
                        input bit sgn, input logic [63:0] wd,
                        input int hold, input bit poke);
        int n;
        bit mis;
        bit ok;
        logic [63:0] exp_rd;
        n = 1 << size;
        mis = (addr % n) != 0;
        exp_rd = (mis || w) ? 64'd0 : model_load(addr, size, sgn);
        if (mis) begin
            if (mcnt < 255) mcnt++;
        end else if (w) begin
            for (int i = 0; i < n; i++) mm[addr+i] = wd[8*i +: 8];
        end
        @(negedge clk);
        reqValid  = 1'b1;
        reqWrite  = w;
        reqAddr   = 11'(addr);
        reqSize   = 2'(size);
        reqSigned = sgn;
        reqWData  = wd;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (reqReady) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 64'(reqReady), 64'd1);
            reqValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(negedge clk);
        chk("lat_access_no_resp", 64'(respValid), 64'd0);
        @(negedge clk);
        chk("lat_resp_valid", 64'(respValid), 64'd1);
        chk("rdata", respRData, exp_rd);
        chk("fault", 64'(respFault), 64'(mis));
        chk("fault_count", 64'(faultCount), 64'(mcnt));
        for (int h = 0; h < hold; h++) begin
            reqValid = poke;
            reqAddr  = 11'd16;
            @(negedge clk);
            chk("hold_valid", 64'(respValid), 64'd1);
            chk("hold_rdata", respRData, exp_rd);
            chk("hold_fault", 64'(respFault), 64'(mis));
            chk("hold_ready", 64'(reqReady), 64'd0);
        end
        reqValid  = 1'b0;
        respReady = 1'b1;
        @(posedge clk);
        #1 respReady = 1'b0;
        chk("resp_done", 64'(respValid), 64'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        mcnt      = 0;
        resetN    = 1'b0;
        reqValid  = 1'b0;
        reqWrite  = 1'b0;
        reqAddr   = '0;
        reqSize   = '0;
        reqSigned = 1'b0;
        reqWData  = '0;
        respReady = 1'b0;
        for (int i = 0; i < 2048; i++) mm[i] = 8'h00;
        #12;
        chk("rst_ready", 64'(reqReady), 64'd1);
        chk("rst_valid", 64'(respValid), 64'd0);
        chk("rst_rdata", respRData, 64'd0);
        chk("rst_fault", 64'(respFault), 64'd0);
        chk("rst_count", 64'(faultCount), 64'd0);
        @(negedge clk);
        resetN = 1'b1;

        for (int a = 0; a < 64; a += 8)
            xact(1'b1, a, 3, 1'b0, {$urandom, $urandom}, 0, 1'b0);

        xact(1'b1, 8, 3, 1'b0, 64'hAAAABBBBAAAABBBB, 0, 1'b0);
        xact(1'b0, 8, 3, 1'b0, 64'd0, 0, 1'b0);
        chk("dbl_const", model_load(8, 3, 1'b0), 64'hAAAABBBBAAAABBBB);
        xact(1'b1, 8, 1, 1'b0, 64'h00000000DDDD4444, 0, 1'b0);
        xact(1'b0, 8, 3, 1'b0, 64'd0, 0, 1'b0);
        xact(1'b0, 10, 0, 1'b1, 64'd0, 0, 1'b0);
        xact(1'b0, 10, 0, 1'b0, 64'd0, 0, 1'b0);
        xact(1'b1, 10, 2, 1'b0, 64'h0000000012345678, 0, 1'b0);
        xact(1'b0, 8, 3, 1'b0, 64'd0, 0, 1'b0);
        for (int i = 0; i < 256; i++)
            xact(1'b0, 9, 1, 1'b0, 64'd0, 0, 1'b0);
        chk("fault_sat", 64'(faultCount), 64'hFF);
        xact(1'b0, 8, 3, 1'b0, 64'd0, 5, 1'b1);

        @(negedge clk);
        reqValid  = 1'b1;
        reqWrite  = 1'b1;
        reqAddr   = 11'd0;
        reqSize   = 2'd1;
        reqSigned = 1'b0;
        reqWData  = 64'h1234;
        @(posedge clk);
        #1 reqValid = 1'b0;
        #2 resetN = 1'b0;
        #1;
        chk("rst2_ready", 64'(reqReady), 64'd1);
        chk("rst2_valid", 64'(respValid), 64'd0);
        chk("rst2_rdata", respRData, 64'd0);
        chk("rst2_fault", 64'(respFault), 64'd0);
        chk("rst2_count", 64'(faultCount), 64'd0);
        mcnt = 0;
        @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        xact(1'b0, 0, 3, 1'b0, 64'd0, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            xact(1'($urandom_range(0, 1)), $urandom_range(0, 63),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, $urandom_range(0, 2),
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
